// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment encodings, nibble encoder and conversion FSM states
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;

    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

    function automatic logic [6:0] seg7_encode(input logic [3:0] nibble);
        case (nibble)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Elaboration-time 10^n, used for the overflow threshold.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bcd_seg_decode.sv
// rtl/bcd_seg_decode.sv - combinational nibble-to-segment mapper with dash/blank override
module bcd_seg_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);

    // Dash wins over blank so an overflowed value never looks like a short number.
    always_comb begin
        if (dash) begin
            seg = SEG_DASH;
        end else if (blank) begin
            seg = SEG_BLANK;
        end else begin
            seg = seg7_encode(nibble);
        end
    end

endmodule

// File: rtl/bcd_scan_display.sv
// rtl/bcd_scan_display.sv - iterative binary-to-BCD plus multiplexed 7-seg scan; option LEADING_ZERO_BLANK_EN
module bcd_scan_display
    import seg7_pkg::*;
#(
    parameter int BIN_W    = 8,
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIN_W-1:0]      bin,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int          WW    = 4 * DIGITS;
    localparam int          CNT_W = $clog2(BIN_W + 1);
    localparam int          DIV_W = $clog2(SCAN_DIV);
    localparam int          IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [63:0] LIMIT = pow10(DIGITS);

    conv_state_t      state;
    logic [BIN_W-1:0] shreg;
    logic [WW-1:0]    work;
    logic [WW-1:0]    work_adj;
    logic [CNT_W-1:0] bit_cnt;
    logic             ovf_next;

    always_comb begin
        work_adj = work;
        for (int i = 0; i < DIGITS; i++) begin
            if (work[4*i +: 4] >= 4'd5) begin
                work_adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
            end
        end
    end

    // Conversion FSM; carries out of the top digit fall off the work register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            ovf_next <= 1'b0;
            bcd      <= '0;
            shreg    <= '0;
            work     <= '0;
            bit_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        shreg    <= bin;
                        work     <= '0;
                        bit_cnt  <= CNT_W'(BIN_W);
                        ovf_next <= (64'(bin) >= LIMIT);
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    work    <= {work_adj[WW-2:0], shreg[BIN_W-1]};
                    shreg   <= shreg << 1;
                    bit_cnt <= bit_cnt - 1'b1;
                    if (bit_cnt == CNT_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bcd   <= work;
                    ovf   <= ovf_next;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [DIV_W-1:0]  div_cnt;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_next;
    logic [DIGITS-1:0] an_next;
    logic [3:0]        nib_next;
    logic              blank_next;
    logic [6:0]        seg_next;
`ifdef LEADING_ZERO_BLANK_EN
    logic              upper_zero;
`endif

    // Select the digit that becomes active at the next slot boundary.
    always_comb begin
        idx_next   = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
        an_next    = '0;
        nib_next   = '0;
        blank_next = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        upper_zero = 1'b1;
`endif
        for (int i = DIGITS - 1; i >= 0; i--) begin
`ifdef LEADING_ZERO_BLANK_EN
            upper_zero = upper_zero & (bcd[4*i +: 4] == 4'd0);
`endif
            if (IDX_W'(i) == idx_next) begin
                an_next[i] = 1'b1;
                nib_next   = bcd[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
                blank_next = (i != 0) && upper_zero;
`endif
            end
        end
    end

    bcd_seg_decode u_decode (
        .nibble (nib_next),
        .blank  (blank_next),
        .dash   (ovf),
        .seg    (seg_next)
    );

    // seg/an change only on terminal count, so a new result never glitches a slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            idx     <= '0;
            an      <= '0;
            seg     <= SEG_BLANK;
        end else if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
            div_cnt <= '0;
            idx     <= idx_next;
            an      <= an_next;
            seg     <= seg_next;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb/tb_bcd_scan_display.sv - scoreboard bench driving a 3-digit and a 2-digit bcd_scan_display
module tb_bcd_scan_display;

    localparam int BIN_W = 8;
    localparam int SD_A  = 4;
    localparam int SD_B  = 3;
    localparam logic [6:0] SEGTAB [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                          7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                          7'b1111111, 7'b1111011};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] bin = 8'd0;

    logic        busy_a, done_a, ovf_a;
    logic [11:0] bcd_a;
    logic [6:0]  seg_a;
    logic [2:0]  an_a;
    logic        busy_b, done_b, ovf_b;
    logic [7:0]  bcd_b;
    logic [6:0]  seg_b;
    logic [1:0]  an_b;

    always #5 clk = ~clk;

    bcd_scan_display #(.BIN_W(BIN_W), .DIGITS(3), .SCAN_DIV(SD_A)) dut_a (
        .clk(clk), .rst(rst), .bin(bin), .start(start), .busy(busy_a), .done(done_a),
        .ovf(ovf_a), .bcd(bcd_a), .seg(seg_a), .an(an_a)
    );

    bcd_scan_display #(.BIN_W(BIN_W), .DIGITS(2), .SCAN_DIV(SD_B)) dut_b (
        .clk(clk), .rst(rst), .bin(bin), .start(start), .busy(busy_b), .done(done_b),
        .ovf(ovf_b), .bcd(bcd_b), .seg(seg_b), .an(an_b)
    );

    typedef struct {
        int          due;
        logic [11:0] bcd_a;
        logic        ovf_a;
        logic [7:0]  bcd_b;
        logic        ovf_b;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   vectors = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   post_done = 1'b0;

    int          m_cnt [2];
    int          m_idx [2];
    logic [2:0]  m_an  [2];
    logic [6:0]  m_seg [2];
    logic [11:0] m_bcd [2];
    logic        m_ovf [2];
    int          digits [2] = '{3, 2};
    int          sdiv   [2] = '{SD_A, SD_B};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int u, input int i);
        logic [3:0] nib;
        if (m_ovf[u]) return 7'b0000001;
        nib = m_bcd[u][4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        if (i > 0 && (m_bcd[u] >> (4*i)) == 12'd0) return 7'b0000000;
`endif
        return SEGTAB[nib];
    endfunction

    // Monitor: scan model advances on each edge, outputs are compared 1 ns later.
    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int u = 0; u < 2; u++) begin
            if (rst) begin
                m_cnt[u] = 0; m_idx[u] = 0; m_an[u] = '0; m_seg[u] = '0;
                m_bcd[u] = '0; m_ovf[u] = 1'b0;
            end else if (m_cnt[u] == sdiv[u] - 1) begin
                m_cnt[u] = 0;
                m_idx[u] = (m_idx[u] + 1) % digits[u];
                m_an[u]  = 3'(1 << m_idx[u]);
                m_seg[u] = exp_seg(u, m_idx[u]);
            end else begin
                m_cnt[u] = m_cnt[u] + 1;
            end
        end
        #1;
        check("an_a", 32'(an_a), 32'(m_an[0]));
        check("seg_a", 32'(seg_a), 32'(m_seg[0]));
        check("an_b", 32'(an_b), 32'(m_an[1]));
        check("seg_b", 32'(seg_b), 32'(m_seg[1]));
        if (post_done) begin
            post_done = 1'b0;
            check("done_a_width", 32'(done_a), 32'd0);
            check("busy_a_after", 32'(busy_a), 32'd0);
            check("busy_b_after", 32'(busy_b), 32'd0);
        end
        if (done_a || done_b) begin
            if (sbq.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_done: got done_a=%0b done_b=%0b, expected none (cycle %0d)",
                         done_a, done_b, cyc);
            end else begin
                e = sbq.pop_front();
                check("done_cycle", 32'(cyc), 32'(e.due));
                check("done_a", 32'(done_a), 32'd1);
                check("done_b", 32'(done_b), 32'd1);
                check("busy_a_in_done", 32'(busy_a), 32'd1);
                check("bcd_a", 32'(bcd_a), 32'(e.bcd_a));
                check("ovf_a", 32'(ovf_a), 32'(e.ovf_a));
                check("bcd_b", 32'(bcd_b), 32'(e.bcd_b));
                check("ovf_b", 32'(ovf_b), 32'(e.ovf_b));
                m_bcd[0] = e.bcd_a;
                m_ovf[0] = e.ovf_a;
                m_bcd[1] = {4'd0, e.bcd_b};
                m_ovf[1] = e.ovf_b;
                post_done = 1'b1;
            end
        end
    end

    task automatic wait_drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic push_exp(input logic [11:0] ea, input logic oa, input logic [7:0] eb, input logic ob);
        exp_t x;
        x.due   = cyc + 1 + BIN_W + 1;
        x.bcd_a = ea;
        x.ovf_a = oa;
        x.bcd_b = eb;
        x.ovf_b = ob;
        sbq.push_back(x);
    endtask

    task automatic convert(input logic [7:0] v, input logic [11:0] ea, input logic oa,
                           input logic [7:0] eb, input logic ob, input int gap);
        @(negedge clk);
        bin   = v;
        start = 1'b1;
        push_exp(ea, oa, eb, ob);
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy_a"}, 32'(busy_a), 32'd0);
        check({tag, "_done_a"}, 32'(done_a), 32'd0);
        check({tag, "_ovf_a"},  32'(ovf_a),  32'd0);
        check({tag, "_bcd_a"},  32'(bcd_a),  32'd0);
        check({tag, "_seg_a"},  32'(seg_a),  32'd0);
        check({tag, "_an_a"},   32'(an_a),   32'd0);
        check({tag, "_busy_b"}, 32'(busy_b), 32'd0);
        check({tag, "_ovf_b"},  32'(ovf_b),  32'd0);
        check({tag, "_bcd_b"},  32'(bcd_b),  32'd0);
        check({tag, "_an_b"},   32'(an_b),   32'd0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        convert(8'd62,  12'h062, 1'b0, 8'h62, 1'b0, 9);
        convert(8'd255, 12'h255, 1'b0, 8'h55, 1'b1, 5);
        convert(8'd150, 12'h150, 1'b0, 8'h50, 1'b1, 13);
        convert(8'd7,   12'h007, 1'b0, 8'h07, 1'b0, 2);
        convert(8'd0,   12'h000, 1'b0, 8'h00, 1'b0, 14);
        convert(8'd100, 12'h100, 1'b0, 8'h00, 1'b1, 3);
        convert(8'd99,  12'h099, 1'b0, 8'h99, 1'b0, 7);

        // start held through the conversion while bin changes underneath
        @(negedge clk);
        bin   = 8'd200;
        start = 1'b1;
        push_exp(12'h200, 1'b0, 8'h00, 1'b1);
        repeat (2) @(negedge clk);
        bin = 8'd99;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_drain();
        convert(8'd99, 12'h099, 1'b0, 8'h99, 1'b0, 10);

        // reset three cycles into a conversion, with start also high
        @(negedge clk);
        bin   = 8'd200;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        bin   = 8'd5;
        @(negedge clk);
        check_reset("abort");
        rst   = 1'b0;
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("busy_a_post_abort", 32'(busy_a), 32'd0);

        convert(8'd62, 12'h062, 1'b0, 8'h62, 1'b0, 16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of stimulus, expected completion by 100000 ns");
        $fatal(1);
    end

endmodule
